// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI transaction arbiter.
// Byte width, maximum transfer length, FSM state encoding and TX alignment helper.
package spi_arb_pkg;

    localparam int SPI_BYTE_W    = 8;
    localparam int ARB_MAX_BYTES = 4;
    localparam int ARB_LEN_W     = 2;
    localparam int ARB_WORD_W    = SPI_BYTE_W * ARB_MAX_BYTES;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } arb_state_t;

    // Left-justify the N = len+1 payload bytes so the first byte to send sits at the top.
    function automatic logic [ARB_WORD_W-1:0] align_tx(input logic [ARB_WORD_W-1:0] payload,
                                                       input logic [ARB_LEN_W-1:0]  len);
        return payload << {~len, 3'b000};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts at the index after last_i.
// The pointer register itself lives in the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic               valid_o,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        valid_o   = 1'b0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        cand      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((int'(last_i) + off) % NUM_REQ);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one byte-level spi_master between NUM_REQ requesters doing 1-4 byte transfers,
// framing each transfer with slave-select setup/hold gaps. reset_i is active-low.
//
//   state | meaning
//   IDLE  | waiting for any request, round-robin grant
//   SETUP | ss_n low, counting CS_SETUP cycles
//   START | issue spi_start with the current byte
//   WAIT  | waiting for spi_done of the current byte
//   HOLD  | counting CS_HOLD cycles after the last byte, then ack
//   GAP   | one idle cycle, busy clears
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [ARB_LEN_W*NUM_REQ-1:0]   len_i,
    input  logic [ARB_WORD_W*NUM_REQ-1:0]  payload_i,
    output logic [NUM_REQ-1:0]             ack_o,
    output logic [ARB_WORD_W-1:0]          rx_word_o,
    output logic                           busy_o,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id_o,
    output logic [NUM_REQ-1:0]             ss_n_o,
    output logic                           spi_start_o,
    output logic [SPI_BYTE_W-1:0]          spi_tx_data_o,
    input  logic                           spi_done_i,
    input  logic [SPI_BYTE_W-1:0]          spi_rx_data_i
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = 4;

    arb_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       grant_id_q, grant_id_d;
    logic [ARB_WORD_W-1:0]  tx_sh_q, tx_sh_d;
    logic [ARB_WORD_W-1:0]  rx_sh_q, rx_sh_d;
    logic [ARB_LEN_W-1:0]   left_q, left_d;
    logic [NUM_REQ-1:0]     ss_n_q, ss_n_d;
    logic                   spi_start_q, spi_start_d;
    logic [SPI_BYTE_W-1:0]  spi_tx_q, spi_tx_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic [ARB_WORD_W-1:0]  rx_word_q, rx_word_d;
    logic                   busy_q, busy_d;

    logic                   rr_valid;
    logic [NUM_REQ-1:0]     rr_gnt;
    logic [IDX_W-1:0]       rr_idx;
    logic [ARB_LEN_W-1:0]   sel_len;
    logic [ARB_WORD_W-1:0]  sel_pay;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i     (req_i),
        .last_i    (ptr_q),
        .valid_o   (rr_valid),
        .gnt_o     (rr_gnt),
        .gnt_idx_o (rr_idx)
    );

    always_comb begin
        sel_len = '0;
        sel_pay = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rr_idx == IDX_W'(i)) begin
                sel_len = len_i[ARB_LEN_W*i +: ARB_LEN_W];
                sel_pay = payload_i[ARB_WORD_W*i +: ARB_WORD_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        grant_id_d  = grant_id_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        left_d      = left_q;
        ss_n_d      = ss_n_q;
        spi_start_d = 1'b0;
        spi_tx_d    = spi_tx_q;
        ack_d       = '0;
        rx_word_d   = rx_word_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (rr_valid) begin
                    grant_id_d = rr_idx;
                    ptr_d      = rr_idx;
                    left_d     = sel_len;
                    tx_sh_d    = align_tx(sel_pay, sel_len);
                    rx_sh_d    = '0;
                    ss_n_d     = ~rr_gnt;
                    busy_d     = 1'b1;
                    cnt_d      = CNT_W'(CS_SETUP - 1);
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) state_d = START;
                else             cnt_d   = cnt_q - 1'b1;
            end
            START: begin
                spi_start_d = 1'b1;
                spi_tx_d    = tx_sh_q[ARB_WORD_W-1 -: SPI_BYTE_W];
                tx_sh_d     = tx_sh_q << SPI_BYTE_W;
                state_d     = WAIT;
            end
            WAIT: begin
                if (spi_done_i) begin
                    rx_sh_d = {rx_sh_q[ARB_WORD_W-SPI_BYTE_W-1:0], spi_rx_data_i};
                    if (left_q == '0) begin
                        // Loaded with CS_HOLD (not -1): the ack edge lands CS_HOLD+1 edges after the last done.
                        cnt_d   = CNT_W'(CS_HOLD);
                        state_d = HOLD;
                    end else begin
                        left_d  = left_q - 1'b1;
                        state_d = START;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    ss_n_d             = '1;
                    ack_d[grant_id_q]  = 1'b1;
                    rx_word_d          = rx_sh_q;
                    state_d            = GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            grant_id_q  <= '0;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            left_q      <= '0;
            ss_n_q      <= '1;
            spi_start_q <= 1'b0;
            spi_tx_q    <= '0;
            ack_q       <= '0;
            rx_word_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            grant_id_q  <= grant_id_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            left_q      <= left_d;
            ss_n_q      <= ss_n_d;
            spi_start_q <= spi_start_d;
            spi_tx_q    <= spi_tx_d;
            ack_q       <= ack_d;
            rx_word_q   <= rx_word_d;
            busy_q      <= busy_d;
        end
    end

    assign ack_o         = ack_q;
    assign rx_word_o     = rx_word_q;
    assign busy_o        = busy_q;
    assign grant_id_o    = grant_id_q;
    assign ss_n_o        = ss_n_q;
    assign spi_start_o   = spi_start_q;
    assign spi_tx_data_o = spi_tx_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: a byte-engine model answers spi_start, a scoreboard
// queue holds the expected acks and transmit bytes, a monitor times the framing.
module tb_spi_txn_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int ENG_LAT  = 2;
    localparam int TMO      = 300;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [3:0]   req = '0;
    logic [7:0]   len = '0;
    logic [127:0] payload = '0;
    logic [3:0]   ack;
    logic [31:0]  rx_word;
    logic         busy;
    logic [1:0]   grant_id;
    logic [3:0]   ss_n;
    logic         spi_start;
    logic [7:0]   spi_tx_data;
    logic         eng_done = 1'b0;
    logic         spur_done = 1'b0;
    logic [7:0]   eng_rx = '0;
    logic         spi_done;
    logic [7:0]   spi_rx;

    assign spi_done = eng_done | spur_done;
    assign spi_rx   = spur_done ? 8'hEE : eng_rx;

    always #5 clk = ~clk;

    spi_txn_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .req_i         (req),
        .len_i         (len),
        .payload_i     (payload),
        .ack_o         (ack),
        .rx_word_o     (rx_word),
        .busy_o        (busy),
        .grant_id_o    (grant_id),
        .ss_n_o        (ss_n),
        .spi_start_o   (spi_start),
        .spi_tx_data_o (spi_tx_data),
        .spi_done_i    (spi_done),
        .spi_rx_data_i (spi_rx)
    );

    typedef struct {
        int          id;
        logic [31:0] rx;
    } exp_t;

    typedef struct {
        int          id;
        logic [1:0]  len;
        logic [31:0] payload;
        logic [31:0] reply;
        logic [31:0] exp_rx;
    } vec_t;

    exp_t        exp_q[$];
    logic [7:0]  tx_exp_q[$];
    logic [7:0]  reply_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          viol = 0;
    int          cyc_n = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Byte engine: answers each start with the next queued reply ENG_LAT cycles later.
    initial begin
        logic [7:0] rb;
        forever begin
            @(negedge clk);
            if (reset && spi_start) begin
                if (tx_exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_unexpected: got %h expected no start", spi_tx_data);
                end else begin
                    chk("tx_byte", 32'(spi_tx_data), 32'(tx_exp_q.pop_front()));
                end
                if (reply_q.size() > 0) rb = reply_q.pop_front();
                else                    rb = 8'h00;
                repeat (ENG_LAT) @(posedge clk);
                #1 eng_done = 1'b1;
                eng_rx = rb;
                @(posedge clk);
                #1 eng_done = 1'b0;
            end
        end
    end

    // Monitor: scoreboard on ack, framing timing and slave-select invariants.
    int         prev_start = 0;
    int         in_txn = 0;
    int         ss_high_run = 100;
    int         fall_cyc = 0;
    int         first_start = -1;
    int         last_done = 0;
    int         busy_chk = 0;
    logic [3:0] ss_at_fall = '1;

    initial begin
        int   lows;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_start  = 0;
                in_txn      = 0;
                ss_high_run = 100;
                first_start = -1;
                busy_chk    = 0;
            end else begin
                lows = $countones(~ss_n);
                if (lows > 1) viol++;
                if (lows == 0) begin
                    if (in_txn != 0 && ack == '0) viol++;
                    ss_high_run++;
                end else begin
                    if (in_txn == 0) begin
                        if (ss_high_run < 2) viol++;
                        in_txn      = 1;
                        fall_cyc    = cyc_n;
                        first_start = -1;
                        ss_at_fall  = ss_n;
                    end else if (ss_n != ss_at_fall) begin
                        viol++;
                    end
                    ss_high_run = 0;
                end
                if (spi_start) begin
                    if (prev_start != 0) viol++;
                    if (first_start < 0) begin
                        chk("setup_cycles", 32'(cyc_n - fall_cyc), 32'(CS_SETUP + 1));
                        first_start = cyc_n;
                    end else begin
                        chk("byte_gap", 32'(cyc_n - last_done), 32'd2);
                    end
                end
                prev_start = int'(spi_start);
                if (eng_done) last_done = cyc_n;
                if (ack != '0) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL ack_unexpected: got ack %b expected none", ack);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_onehot", 32'(ack), 32'd1 << e.id);
                        chk("rx_word", rx_word, e.rx);
                        chk("grant_id", 32'(grant_id), 32'(e.id));
                        chk("hold_cycles", 32'(cyc_n - last_done), 32'(CS_HOLD + 2));
                        chk("busy_at_ack", 32'(busy), 32'd1);
                    end
                    in_txn   = 0;
                    busy_chk = 1;
                end else if (busy_chk != 0) begin
                    chk("busy_after_ack", 32'(busy), 32'd0);
                    busy_chk = 0;
                end
            end
        end
    end

    task automatic wait_any_ack();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == '0 && n < TMO);
        chk("ack_wait_timeout", 32'(n >= TMO), 32'd0);
    endtask

    task automatic push_txn(input vec_t v);
        len[2*v.id +: 2]      = v.len;
        payload[32*v.id +: 32] = v.payload;
        for (int b = int'(v.len); b >= 0; b--) begin
            tx_exp_q.push_back(v.payload[8*b +: 8]);
            reply_q.push_back(v.reply[8*b +: 8]);
        end
        exp_q.push_back('{v.id, v.exp_rx});
    endtask

    task automatic run_vec(input vec_t v);
        push_txn(v);
        req[v.id] = 1'b1;
        wait_any_ack();
        req[v.id] = 1'b0;
    endtask

    vec_t vecs[4];
    vec_t v;

    initial begin
        vecs[0] = '{0, 2'd1, 32'h0000_12A5, 32'h0000_3C5A, 32'h0000_3C5A};
        vecs[1] = '{3, 2'd3, 32'hDEAD_BEEF, 32'h1122_3344, 32'h1122_3344};
        vecs[2] = '{1, 2'd0, 32'hFFFF_FF77, 32'hAAAA_AA81, 32'h0000_0081};
        vecs[3] = '{2, 2'd2, 32'h99AB_CDEF, 32'h55C0_FFEE, 32'h00C0_FFEE};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ss_n", 32'(ss_n), 32'hF);
        chk("rst_spi_start", 32'(spi_start), 32'd0);
        chk("rst_tx_data", 32'(spi_tx_data), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rx_word", rx_word, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // All requesters held high: expect grants 0,1,2,3,0
        for (int i = 0; i < NUM_REQ; i++) begin
            len[2*i +: 2]      = 2'd0;
            payload[32*i +: 32] = 32'hABCD_EF00 | 32'(8'h10 + 8'h11 * i);
        end
        for (int g = 0; g < 5; g++) begin
            int id;
            id = g % NUM_REQ;
            tx_exp_q.push_back(8'(8'h10 + 8'h11 * id));
            reply_q.push_back(8'(8'h90 + id));
            exp_q.push_back('{id, 32'(8'h90 + id)});
        end
        req = 4'b1111;
        for (int g = 0; g < 5; g++) wait_any_ack();
        req = '0;
        repeat (3) @(negedge clk);

        // Table vectors
        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i]);
            repeat (2) @(negedge clk);
        end

        // Spurious done in IDLE
        @(posedge clk);
        #1 spur_done = 1'b1;
        @(posedge clk);
        #1 spur_done = 1'b0;
        @(negedge clk);
        chk("spur_idle_ack", 32'(ack), 32'd0);
        chk("spur_idle_busy", 32'(busy), 32'd0);
        chk("spur_idle_ss_n", 32'(ss_n), 32'hF);
        chk("spur_idle_start", 32'(spi_start), 32'd0);

        // Spurious done in SETUP must not consume a byte
        v = '{0, 2'd1, 32'h0000_6789, 32'h0000_1357, 32'h0000_1357};
        push_txn(v);
        req[0] = 1'b1;
        @(posedge clk);
        #1 spur_done = 1'b1;
        @(posedge clk);
        #1 spur_done = 1'b0;
        wait_any_ack();
        req[0] = 1'b0;
        repeat (2) @(negedge clk);

        // req[1] dropped during SETUP: transfer completes, no regrant
        v = '{1, 2'd1, 32'h0000_BEEF, 32'h0000_4242, 32'h0000_4242};
        push_txn(v);
        req[1] = 1'b1;
        @(negedge clk);
        req[1] = 1'b0;
        wait_any_ack();
        repeat (20) @(negedge clk);
        chk("drop_ss_n_idle", 32'(ss_n), 32'hF);
        chk("drop_busy_idle", 32'(busy), 32'd0);
        chk("drop_grant_id", 32'(grant_id), 32'd1);

        // Reset during WAIT of byte 2, then clean regrant of req[2]
        v = '{2, 2'd2, 32'h00A1_B2C3, 32'h0044_5566, 32'h0044_5566};
        push_txn(v);
        req[2] = 1'b1;
        begin
            int ns = 0;
            int n  = 0;
            while (ns < 2 && n < TMO) begin
                @(negedge clk);
                n++;
                if (spi_start) ns++;
            end
            chk("start2_wait_timeout", 32'(n >= TMO), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_ss_n", 32'(ss_n), 32'hF);
        chk("midrst_start", 32'(spi_start), 32'd0);
        chk("midrst_ack", 32'(ack), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rx_word", rx_word, 32'd0);
        exp_q.delete();
        tx_exp_q.delete();
        reply_q.delete();
        v = '{2, 2'd2, 32'h00A1_B2C3, 32'h0077_8899, 32'h0077_8899};
        push_txn(v);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_any_ack();
        req[2] = 1'b0;
        repeat (5) @(negedge clk);

        chk("invariant_violations", 32'(viol), 32'd0);
        chk("pending_acks", 32'(exp_q.size()), 32'd0);
        chk("pending_tx", 32'(tx_exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1);
    end

endmodule

// File: doc/spi_txn_arbiter.md
# spi_txn_arbiter

Sequences and shares the single byte-level `spi_master` engine between `NUM_REQ` independent requesters, each issuing 1-4 byte SPI transactions. The arbiter grants the engine round-robin and owns one active-low slave select per requester. It frames each multi-byte transfer with programmable select setup/hold gaps and returns the received bytes as one word. It sits between the counter/sensor-side control logic and `spi_master`.

## Interface
- `NUM_REQ`, 4: number of requesters and slave selects (2..8).
- `CS_SETUP`, 2: cycles from `ss_n` fall to first `spi_start`, 1..15.
- `CS_HOLD`, 2: cycles from last `spi_done` to `ss_n` rise, 1..15.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  level request per requester.
- `len`  in  2*NUM_REQ  per requester byte count minus one; slice i is `[2i+1:2i]`.
- `payload`  in  32*NUM_REQ  per requester transmit bytes; slice i is `[32i+31:32i]`.
- `ack`  out  NUM_REQ  one-hot, one-cycle completion pulse.
- `rx_word`  out  32  received bytes, valid in the `ack` cycle.
- `busy`  out  1  high from grant until the cycle after `ack`.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- `ss_n`  out  NUM_REQ  active-low slave selects.
- `spi_start`  out  1  one-cycle start strobe to `spi_master`.
- `spi_tx_data`  out  8  byte to `spi_master`.
- `spi_done`  in  1  byte-complete pulse from `spi_master`.
- `spi_rx_data`  in  8  byte received, valid with `spi_done`.

## Operation
- All outputs are registered. Reset values: `ss_n` all 1, `spi_start` 0, `spi_tx_data` 0, `ack` 0, `rx_word` 0, `busy` 0, `grant_id` 0. The round-robin pointer resets so that index 0 has highest priority.
- **IDLE**: if any `req` is set, pick the winner round-robin, starting from the index after the last grant.
  - Latch the winner's `len` and `payload`; set `grant_id`.
  - Drive the winner's `ss_n` low and set `busy`.
  - Go to SETUP.
- **SETUP**: count `CS_SETUP` cycles, then go to START.
- **START**: pulse `spi_start` with `spi_tx_data` set to the current byte. Go to WAIT.
- **WAIT**: on `spi_done`:
  - Shift `spi_rx_data` into the rx shift register from the LSB side.
  - Decrement the remaining-byte count.
  - If bytes remain, go to START; otherwise go to HOLD.
- **HOLD**: count `CS_HOLD` cycles, then:
  - Raise `ss_n`.
  - Pulse `ack[grant_id]` and present `rx_word`.
  - Go to GAP.
- **GAP**: one cycle. Clear `busy`, return to IDLE. This guarantees at least one idle cycle and `ss_n` high for at least 2 cycles between transactions.
- Byte order, with N = `len`+1:
  - Transmit order is MSB-first from payload bits `[8N-1:0]`: byte `[8N-1:8N-8]` first, byte `[7:0]` last.
  - `rx_word` is right-aligned with the first received byte most significant. Unused upper bits are 0.
- Requester contract: hold `req` until `ack`. `len`/`payload` are sampled only at grant.
  - Dropping `req` mid-transaction does not abort it; the transaction completes and `ack` still pulses.
  - A `req` still high in the cycle after `ack` is treated as a new request.
- `spi_done` outside WAIT is ignored.
- At most one `ss_n` bit is low at any time.
- Reset asserted mid-transaction immediately forces the reset values: `ss_n` high, no `spi_start`, no `ack`.

## Timing
- Grant latency: `req` sampled high in IDLE at edge k gives `ss_n` low after edge k.
- First `spi_start` is high for the cycle after edge k+1+`CS_SETUP`.
- Byte-to-byte: `spi_done` at edge m gives next `spi_start` high after edge m+1, so consecutive bytes are separated by 2 cycles plus engine time.
- Last `spi_done` at edge m gives `ss_n` high and `ack` after edge m+1+`CS_HOLD`; `busy` low one cycle later.
- `spi_start` is never high in two consecutive cycles.

## Structure
- Shared package `spi_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, SETUP, START, WAIT, HOLD, GAP);
  - the constants `SPI_BYTE_W`=8, `ARB_MAX_BYTES`=4 and `ARB_LEN_W`=2.
- One sub-module, `rr_arbiter`: a combinational round-robin picker. It takes `req` and the last-grant pointer and returns the one-hot grant and its index. The pointer register stays in the parent.

## Test plan
- Single request, `len`=1, payload `0x0000_12A5`, engine echoes `0x3C` then `0x5A`:
  - `spi_tx_data` is 0x12 then 0xA5;
  - `rx_word`=`0x0000_3C5A` with `ack[0]`;
  - `ss_n[0]` stays low for the whole transfer, setup/hold cycle counts exact.
- `req`=4'b1111 held continuously: grants in order 0,1,2,3,0. Exactly one `ss_n` is low at a time, and there are ≥2 high cycles between transactions.
- `len`=3, payload `0xDEADBEEF`: four starts sending DE, AD, BE, EF; `rx_word` is the four echoed bytes in order.
- Spurious `spi_done` in IDLE and in SETUP: no state change, no `ack`, byte count unaffected.
- Reset asserted during WAIT of byte 2: outputs at reset values the same cycle. After release, a pending `req[2]` is granted cleanly from byte 1.
- `req[1]` dropped during SETUP: the transaction completes, `ack[1]` pulses, and no further grant to 1.
